// File: rtl/btn_debounce_repeat.sv
// btn_debounce_repeat
//   Conditions one raw push-button before a 1-bit CPU input port samples it:
//   two-flop synchroniser, polarity normalisation, counter debouncer, and
//   hold-to-auto-repeat pulses for fast hour/minute setting.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   reset_n        synchronous active-low reset
//   btn_raw        asynchronous raw button pin
//   repeat_en      1 = auto-repeat enabled (sampled every cycle)
//   btn_level      debounced level, 1 = pressed
//   press_pulse    one-cycle pulse on an accepted press
//   release_pulse  one-cycle pulse on an accepted release
//   repeat_pulse   one-cycle pulse per auto-repeat tick
module btn_debounce_repeat #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic             RAW_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST      = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST      = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_e;

  logic             sync_p0_q;
  logic             sync_p1_q;
  logic             smp;
  logic [CNT_W-1:0] dcnt_q;
  logic [CNT_W-1:0] dcnt_d;
  logic             level_q;
  logic             level_d;
  logic             rise;
  logic             fall;
  logic             press_q;
  logic             release_q;
  state_e           state_q;
  logic [CNT_W-1:0] rcnt_q;
  logic             repeat_q;

  // Synchroniser stage; reset parks it at the released pin level so that
  // leaving reset never looks like a transition.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0_q <= RAW_RELEASED;
      sync_p1_q <= RAW_RELEASED;
    end else begin
      sync_p0_q <= btn_raw;
      sync_p1_q <= sync_p0_q;
    end
  end

  // Normalised sample: 1 = pressed regardless of pin polarity.
  assign smp = (ACTIVE_LOW != 0) ? ~sync_p1_q : sync_p1_q;

  // Debounce stage: any sample agreeing with the accepted level restarts
  // the count; DEBOUNCE_CYCLES disagreeing samples in a row flip it.
  always_comb begin
    dcnt_d  = '0;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (smp != level_q) begin
      if (dcnt_q == DB_LAST) begin
        level_d = smp;
        rise    = smp;
        fall    = ~smp;
      end else begin
        dcnt_d = dcnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= rise;
      release_q <= fall;
    end
  end

  // Repeat stage: release or repeat_en low wins over any terminal count, so
  // no repeat tick can land on the release edge. Only a fresh accepted press
  // arms the delay; enabling repeat mid-hold leaves the FSM idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      if (fall || !repeat_en) begin
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            rcnt_q <= '0;
            if (rise) begin
              state_q <= ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (rcnt_q == RD_LAST) begin
              state_q  <= ST_REPEAT;
              rcnt_q   <= '0;
              repeat_q <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + CNT_ONE;
            end
          end
          ST_REPEAT: begin
            if (rcnt_q == RR_LAST) begin
              rcnt_q   <= '0;
              repeat_q <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_btn_debounce_repeat.sv
module tb_btn_debounce_repeat;

  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RR = 5;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_raw;
  logic repeat_en;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  int checks   = 0;
  int failures = 0;
  int n_press  = 0;
  int n_rel    = 0;
  int n_rep    = 0;
  int n_clash  = 0;

  btn_debounce_repeat #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .ACTIVE_LOW     (1),
    .CNT_W          (25)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_raw      (btn_raw),
    .repeat_en    (repeat_en),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One active edge, then sample 1 ns later and tally pulses.
  task automatic step();
    @(posedge clk);
    #1;
    n_press += int'(press_pulse);
    n_rel   += int'(release_pulse);
    n_rep   += int'(repeat_pulse);
    if ((press_pulse && (release_pulse || repeat_pulse)) ||
        (release_pulse && repeat_pulse))
      n_clash++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    n_press = 0;
    n_rel   = 0;
    n_rep   = 0;
  endtask

  function automatic int outs();
    return int'({btn_level, press_pulse, release_pulse, repeat_pulse});
  endfunction

  initial begin
    reset_n   = 1'b0;
    btn_raw   = 1'b1;
    repeat_en = 1'b1;
    steps(3);
    check_eq("reset_level",   int'(btn_level), 0);
    check_eq("reset_press",   int'(press_pulse), 0);
    check_eq("reset_release", int'(release_pulse), 0);
    check_eq("reset_repeat",  int'(repeat_pulse), 0);
    reset_n = 1'b1;
    steps(3);
    clr();

    // Clean press then auto-repeat while held
    btn_raw = 1'b0;
    steps(5);
    check_eq("press_e5_level", int'(btn_level), 0);
    check_eq("press_e5_npress", n_press, 0);
    step();
    check_eq("press_e6_level", int'(btn_level), 1);
    check_eq("press_e6_pulse", int'(press_pulse), 1);
    step();
    check_eq("press_e7_pulse", int'(press_pulse), 0);
    steps(8);
    check_eq("rep_e15", int'(repeat_pulse), 0);
    step();
    check_eq("rep_e16", int'(repeat_pulse), 1);
    step();
    check_eq("rep_e17", int'(repeat_pulse), 0);
    steps(3);
    step();
    check_eq("rep_e21", int'(repeat_pulse), 1);
    steps(4);
    step();
    check_eq("rep_e26", int'(repeat_pulse), 1);
    steps(4);
    step();
    check_eq("rep_e31", int'(repeat_pulse), 1);
    check_eq("rep_count", n_rep, 4);
    check_eq("press_count", n_press, 1);

    // Release from REPEAT: one more tick lands on release edge 5, level falls at 6
    clr();
    btn_raw = 1'b1;
    steps(5);
    check_eq("rel_e5_level", int'(btn_level), 1);
    check_eq("rel_e5_nrep", n_rep, 1);
    step();
    check_eq("rel_e6_level", int'(btn_level), 0);
    check_eq("rel_e6_pulse", int'(release_pulse), 1);
    steps(10);
    check_eq("rel_after_nrep", n_rep, 1);
    check_eq("rel_after_nrel", n_rel, 1);

    // Bounce rejection: 3 low / 3 high, five times
    clr();
    for (int k = 0; k < 5; k++) begin
      btn_raw = 1'b0;
      steps(3);
      btn_raw = 1'b1;
      steps(3);
    end
    steps(10);
    check_eq("bounce_level", int'(btn_level), 0);
    check_eq("bounce_pulses", n_press + n_rel + n_rep, 0);

    // Release while in DELAY
    clr();
    btn_raw = 1'b0;
    steps(6);
    check_eq("dly_e6_press", int'(press_pulse), 1);
    steps(2);
    btn_raw = 1'b1;
    steps(5);
    check_eq("dly_e13_level", int'(btn_level), 1);
    step();
    check_eq("dly_e14_level", int'(btn_level), 0);
    check_eq("dly_e14_release", int'(release_pulse), 1);
    steps(20);
    check_eq("dly_nrep", n_rep, 0);
    check_eq("dly_nrel", n_rel, 1);

    // repeat_en low during hold, then raised mid-hold
    clr();
    repeat_en = 1'b0;
    btn_raw   = 1'b0;
    steps(100);
    check_eq("noen_npress", n_press, 1);
    check_eq("noen_nrep", n_rep, 0);
    check_eq("noen_level", int'(btn_level), 1);
    repeat_en = 1'b1;
    steps(40);
    check_eq("lateen_nrep", n_rep, 0);
    btn_raw = 1'b1;
    steps(10);
    check_eq("lateen_nrel", n_rel, 1);
    check_eq("lateen_level", int'(btn_level), 0);
    clr();
    btn_raw = 1'b0;
    steps(15);
    check_eq("repress_e15_nrep", n_rep, 0);
    step();
    check_eq("repress_e16_rep", int'(repeat_pulse), 1);

    // Reset while held past the first repeat
    steps(5);
    reset_n = 1'b0;
    step();
    check_eq("midrst_e1_outs", outs(), 0);
    step();
    check_eq("midrst_e2_outs", outs(), 0);
    reset_n = 1'b1;
    clr();
    steps(5);
    check_eq("postrst_e5_level", int'(btn_level), 0);
    check_eq("postrst_e5_npress", n_press, 0);
    step();
    check_eq("postrst_e6_press", int'(press_pulse), 1);
    check_eq("postrst_e6_level", int'(btn_level), 1);
    steps(9);
    check_eq("postrst_e15_nrep", n_rep, 0);
    step();
    check_eq("postrst_e16_rep", int'(repeat_pulse), 1);
    check_eq("postrst_nrel", n_rel, 0);

    check_eq("pulse_clash", n_clash, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
